// File: rtl/amt_multi_retire_pkg.sv
// Shared types and sizing for the architectural map table (amt_multi_retire).
// Optional feature macro used by the design: AMT_R0_ZERO_EN (arch reg 0 hardwired to tag 0).
`ifndef RT_NUM
`define RT_NUM 2
`endif
`ifndef ARCH_REG_NUM
`define ARCH_REG_NUM 32
`endif
`ifndef TAG_IDX_WIDTH
`define TAG_IDX_WIDTH 6
`endif

package amt_multi_retire_pkg;

   localparam int unsigned C_RT_NUM        = `RT_NUM;
   localparam int unsigned C_ARCH_REG_NUM  = `ARCH_REG_NUM;
   localparam int unsigned C_TAG_IDX_WIDTH = `TAG_IDX_WIDTH;
   localparam int unsigned C_RECOV_PER_CYC = 4;

   // Index into the table, and a retire-port field one bit wider so out-of-range
   // requests from the ROB can be expressed and rejected.
   localparam int unsigned ARCH_IDX_W = $clog2(C_ARCH_REG_NUM);
   localparam int unsigned ARCH_REG_W = $clog2(C_ARCH_REG_NUM + 1);

   // Recovery walk length and beat counter width.
   localparam int unsigned BEAT_NUM = C_ARCH_REG_NUM / C_RECOV_PER_CYC;
   localparam int unsigned BEAT_W   = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;

   typedef logic [C_TAG_IDX_WIDTH-1:0] amt_entry_t;

   typedef struct packed {
      logic                  wr_en;
      logic [ARCH_REG_W-1:0] arch_reg;
      amt_entry_t            phy_reg;
   } rob_amt_t;

   typedef struct packed {
      logic       valid;
      amt_entry_t tag;
   } amt_free_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WALK = 1'b1
   } amt_state_e;

endpackage

// File: rtl/amt_multi_retire_free_calc.sv
// amt_free_calc: combinational intra-cycle retire resolution.
// Produces per-channel freed tags and the next table contents.
// Honours AMT_R0_ZERO_EN (writes to arch reg 0 accepted but without effect).
module amt_free_calc
   import amt_multi_retire_pkg::*;
(
   input  logic       accept_i,
   input  amt_entry_t amt_i     [C_ARCH_REG_NUM],
   input  rob_amt_t   rob_amt_i [C_RT_NUM],
   output amt_free_t  free_o    [C_RT_NUM],
   output amt_entry_t amt_nxt_o [C_ARCH_REG_NUM]
);

   logic [C_RT_NUM-1:0] upd;
   logic [ARCH_IDX_W-1:0] idx [C_RT_NUM];

   // Qualify each channel: accepted, in range and not targeting a hardwired entry.
   always_comb begin
      for (int j = 0; j < int'(C_RT_NUM); j++) begin
         idx[j] = rob_amt_i[j].arch_reg[ARCH_IDX_W-1:0];
         upd[j] = accept_i && rob_amt_i[j].wr_en &&
                  (rob_amt_i[j].arch_reg < ARCH_REG_W'(C_ARCH_REG_NUM));
`ifdef AMT_R0_ZERO_EN
         if (rob_amt_i[j].arch_reg == '0) begin
            upd[j] = 1'b0;
         end
`endif
      end
   end

   // Freed tag: the youngest older same-cycle writer of the entry, else the pre-cycle value.
   always_comb begin
      for (int j = 0; j < int'(C_RT_NUM); j++) begin
         free_o[j].valid = upd[j];
         free_o[j].tag   = '0;
         if (upd[j]) begin
            free_o[j].tag = amt_i[idx[j]];
            for (int k = 0; k < j; k++) begin
               if (upd[k] && (idx[k] == idx[j])) begin
                  free_o[j].tag = rob_amt_i[k].phy_reg;
               end
            end
         end
      end
   end

   // Next table: apply channels in program order so the youngest writer wins.
   always_comb begin
      amt_nxt_o = amt_i;
      for (int j = 0; j < int'(C_RT_NUM); j++) begin
         if (upd[j]) begin
            amt_nxt_o[idx[j]] = rob_amt_i[j].phy_reg;
         end
      end
`ifdef AMT_R0_ZERO_EN
      amt_nxt_o[0] = '0;
`endif
   end

endmodule

// File: rtl/amt_multi_retire.sv
// amt_multi_retire: retire-stage architectural map table with freelist return
// and a multi-cycle recovery walk toward the rename map table on rollback.
// Optional feature macro: AMT_R0_ZERO_EN (entry 0 hardwired to tag 0).
module amt_multi_retire
   import amt_multi_retire_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rollback_i,
   input  rob_amt_t              rob_amt_i     [C_RT_NUM],
   output logic                  amt_ready_o,
   output amt_entry_t            amt_o         [C_ARCH_REG_NUM],
   output logic [C_RT_NUM-1:0]   free_valid_o,
   output amt_entry_t            free_tag_o    [C_RT_NUM],
   output logic                  recov_valid_o,
   output logic [ARCH_IDX_W-1:0] recov_base_o,
   output amt_entry_t            recov_tag_o   [C_RECOV_PER_CYC],
   output logic                  recov_done_o
);

   amt_entry_t            amt_q [C_ARCH_REG_NUM];
   amt_entry_t            amt_d [C_ARCH_REG_NUM];
   amt_free_t             free_c [C_RT_NUM];
   logic [C_RT_NUM-1:0]   free_valid_q, free_valid_d;
   amt_entry_t            free_tag_q [C_RT_NUM];
   amt_entry_t            free_tag_d [C_RT_NUM];
   amt_state_e            state_q, state_d;
   logic [BEAT_W:0]       beat_q, beat_d;
   logic                  ready_q, ready_d;
   logic                  recov_valid_q, recov_valid_d;
   logic [ARCH_IDX_W-1:0] recov_base_q, recov_base_d;
   amt_entry_t            recov_tag_q [C_RECOV_PER_CYC];
   amt_entry_t            recov_tag_d [C_RECOV_PER_CYC];
   logic                  recov_done_q, recov_done_d;
   logic                  emit;
   logic [BEAT_W-1:0]     emit_beat;

   amt_free_calc u_free_calc (
      .accept_i  (ready_q),
      .amt_i     (amt_q),
      .rob_amt_i (rob_amt_i),
      .free_o    (free_c),
      .amt_nxt_o (amt_d)
   );

   // Freed tags are registered straight from the resolver.
   always_comb begin
      for (int j = 0; j < int'(C_RT_NUM); j++) begin
         free_valid_d[j] = free_c[j].valid;
         free_tag_d[j]   = free_c[j].tag;
      end
   end

   // Walk FSM: beat_q holds the next beat to emit; beats read the post-commit table.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      recov_valid_d = 1'b0;
      recov_done_d  = 1'b0;
      recov_base_d  = '0;
      emit          = 1'b0;
      emit_beat     = '0;
      for (int i = 0; i < int'(C_RECOV_PER_CYC); i++) begin
         recov_tag_d[i] = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (rollback_i) begin
               state_d = ST_WALK;
               emit    = 1'b1;
            end
         end
         ST_WALK: begin
            if (rollback_i) begin
               emit = 1'b1;
            end else if (beat_q == (BEAT_W+1)'(BEAT_NUM)) begin
               state_d = ST_IDLE;
            end else begin
               emit      = 1'b1;
               emit_beat = beat_q[BEAT_W-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (emit) begin
         recov_valid_d = 1'b1;
         recov_done_d  = (emit_beat == BEAT_W'(BEAT_NUM - 1));
         beat_d        = {1'b0, emit_beat} + (BEAT_W+1)'(1);
         recov_base_d  = ARCH_IDX_W'(32'(emit_beat) * C_RECOV_PER_CYC);
         for (int i = 0; i < int'(C_RECOV_PER_CYC); i++) begin
            recov_tag_d[i] = amt_d[ARCH_IDX_W'(32'(emit_beat) * C_RECOV_PER_CYC + 32'(i))];
         end
      end

      ready_d = (state_d == ST_IDLE);
   end

   // State, table and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(C_ARCH_REG_NUM); i++) begin
            amt_q[i] <= C_TAG_IDX_WIDTH'(i);
         end
         free_valid_q <= '0;
         for (int j = 0; j < int'(C_RT_NUM); j++) begin
            free_tag_q[j] <= '0;
         end
         state_q       <= ST_IDLE;
         beat_q        <= '0;
         ready_q       <= 1'b1;
         recov_valid_q <= 1'b0;
         recov_base_q  <= '0;
         recov_done_q  <= 1'b0;
         for (int i = 0; i < int'(C_RECOV_PER_CYC); i++) begin
            recov_tag_q[i] <= '0;
         end
      end else begin
         amt_q         <= amt_d;
         free_valid_q  <= free_valid_d;
         free_tag_q    <= free_tag_d;
         state_q       <= state_d;
         beat_q        <= beat_d;
         ready_q       <= ready_d;
         recov_valid_q <= recov_valid_d;
         recov_base_q  <= recov_base_d;
         recov_done_q  <= recov_done_d;
         recov_tag_q   <= recov_tag_d;
      end
   end

   assign amt_o         = amt_q;
   assign amt_ready_o   = ready_q;
   assign free_valid_o  = free_valid_q;
   assign free_tag_o    = free_tag_q;
   assign recov_valid_o = recov_valid_q;
   assign recov_base_o  = recov_base_q;
   assign recov_tag_o   = recov_tag_q;
   assign recov_done_o  = recov_done_q;

endmodule
